user_id_readout: RTL and testbench

Read-side controller for the user project ID word. After reset it captures the 32-bit `mask_rev` value driven by the ID programming cells, checks that it is stable, and holds it in a shadow register. It then shares that register between two requesters: a Wishbone slave port used by the management core and a byte-wide request port used by housekeeping SPI. Ties between the two are resolved by round-robin arbitration.

---
 rtl/user_id_readout.sv | 139 +++++++++++++
 tb/tb_user_id_readout.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_id_readout.sv
// user_id_readout: captures and verifies the mask_rev ID word, then serves
// it read-only to a Wishbone slave port and a byte-wide SPI request port.
module user_id_readout #(
    parameter logic [31:0] BASE_ADR      = 32'h2620_0010,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] mask_rev_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        spi_req_i,
    input  logic [1:0]  spi_idx_i,
    output logic        spi_gnt_o,
    output logic        spi_valid_o,
    output logic [7:0]  spi_byte_o,
    output logic        id_valid_o,
    output logic [3:0]  mismatch_cnt_o
);

    typedef enum logic [2:0] {
        CAPT_A,
        CAPT_B,
        IDLE,
        SERVE_WB,
        SERVE_SPI
    } state_t;

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [31:0] shadow, shadow_nx;
    logic [31:0] id_reg, id_nx;
    logic [31:0] dat_nx;
    logic [7:0]  byte_nx;
    logic [3:0]  mm_nx;
    logic        ack_nx, valid_nx, idv_nx;
    logic        last_spi, last_spi_nx;
    logic        wb_req, wb_win, terminal, free;

    assign wb_req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i == BASE_ADR);
    assign wb_win    = wb_req & (~spi_req_i | last_spi);
    assign terminal  = (cnt == LAST);
    // an ack/valid still high means its requester may not have dropped yet
    assign free      = ~wbs_ack_o & ~spi_valid_o;
    assign spi_gnt_o = (state == SERVE_SPI);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= CAPT_A;
            cnt            <= '0;
            shadow         <= '0;
            id_reg         <= '0;
            wbs_dat_o      <= '0;
            wbs_ack_o      <= 1'b0;
            spi_valid_o    <= 1'b0;
            spi_byte_o     <= '0;
            id_valid_o     <= 1'b0;
            mismatch_cnt_o <= '0;
            last_spi       <= 1'b1;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            shadow         <= shadow_nx;
            id_reg         <= id_nx;
            wbs_dat_o      <= dat_nx;
            wbs_ack_o      <= ack_nx;
            spi_valid_o    <= valid_nx;
            spi_byte_o     <= byte_nx;
            id_valid_o     <= idv_nx;
            mismatch_cnt_o <= mm_nx;
            last_spi       <= last_spi_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        shadow_nx   = shadow;
        id_nx       = id_reg;
        dat_nx      = '0;
        ack_nx      = 1'b0;
        valid_nx    = 1'b0;
        byte_nx     = '0;
        idv_nx      = id_valid_o;
        mm_nx       = mismatch_cnt_o;
        last_spi_nx = last_spi;
        unique case (state)
            CAPT_A: begin
                if (terminal) begin
                    shadow_nx = mask_rev_i;
                    cnt_nx    = '0;
                    state_nx  = CAPT_B;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            CAPT_B: begin
                if (terminal) begin
                    cnt_nx = '0;
                    if (mask_rev_i == shadow) begin
                        id_nx    = shadow;
                        idv_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        shadow_nx = mask_rev_i;
                        if (mismatch_cnt_o != 4'hF)
                            mm_nx = mismatch_cnt_o + 4'd1;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            IDLE: begin
                if (free && (wb_req || spi_req_i)) begin
                    last_spi_nx = ~wb_win;
                    state_nx    = wb_win ? SERVE_WB : SERVE_SPI;
                end
            end
            SERVE_WB: begin
                ack_nx   = 1'b1;
                dat_nx   = wbs_we_i ? 32'h0 : id_reg;
                state_nx = IDLE;
            end
            SERVE_SPI: begin
                valid_nx = 1'b1;
                byte_nx  = id_reg[{spi_idx_i, 3'b000} +: 8];
                state_nx = IDLE;
            end
            default: state_nx = CAPT_A;
        endcase
    end

endmodule

// File: tb/tb_user_id_readout.sv
// tb_user_id_readout: directed capture/reset checks plus a randomized
// access phase scored against a cycle-scheduled arbitration model.
module tb_user_id_readout;

    localparam logic [31:0] BASE = 32'h2620_0010;
    localparam int S  = 8;
    localparam int NC = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mask = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat;
    logic        ack;
    logic        req = 1'b0;
    logic [1:0]  idx = '0;
    logic        gnt, vld, idv;
    logic [7:0]  byt;
    logic [3:0]  mmc;

    int checks = 0;
    int errors = 0;

    user_id_readout #(.BASE_ADR(BASE), .SETTLE_CYCLES(S)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .mask_rev_i(mask),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i(we),
        .wbs_adr_i(adr),
        .wbs_dat_o(dat),
        .wbs_ack_o(ack),
        .spi_req_i(req),
        .spi_idx_i(idx),
        .spi_gnt_o(gnt),
        .spi_valid_o(vld),
        .spi_byte_o(byt),
        .id_valid_o(idv),
        .mismatch_cnt_o(mmc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick(input logic [31:0] w,
                                        input logic [1:0] i);
        return 8'(w >> (8 * int'(i)));
    endfunction

    bit          e_ack[0:NC+3];
    bit          e_gnt[0:NC+3];
    bit          e_vld[0:NC+3];
    logic [31:0] e_dat[0:NC+3];
    logic [7:0]  e_byt[0:NC+3];

    initial begin
        logic [31:0] id;
        logic [7:0]  exp_b[4];
        int          free_at;
        bit          last_spi;
        bit          wbp, wwin, seen;
        int          bad_cnt;

        id = 32'hA5C3_0F1E;
        exp_b[0] = 8'h1E; exp_b[1] = 8'h0F;
        exp_b[2] = 8'hC3; exp_b[3] = 8'hA5;
        for (int i = 0; i < NC + 4; i++) begin
            e_ack[i] = 0; e_gnt[i] = 0; e_vld[i] = 0;
            e_dat[i] = '0; e_byt[i] = '0;
        end

        // capture with a stable word
        mask = id;
        repeat (3) step();
        check("rst_idv", 32'(idv), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_dat", dat, 0);
        check("rst_vld", 32'(vld), 0);
        check("rst_byte", 32'(byt), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_mm", 32'(mmc), 0);
        rst = 1'b0;
        repeat (2 * S - 1) step();
        check("idv_early", 32'(idv), 0);
        step();
        check("idv_rise", 32'(idv), 1);
        check("mm_zero", 32'(mmc), 0);

        // wrong address is never acked
        cyc = 1; stb = 1; adr = BASE + 32'd4;
        seen = 0;
        repeat (20) begin
            step();
            if (ack) seen = 1;
        end
        check("bad_adr_ack", 32'(seen), 0);
        cyc = 0; stb = 0; adr = BASE;

        // randomized accesses, opening with a tie
        free_at = 0;
        last_spi = 1;
        bad_cnt = 0;
        cyc = 1; stb = 1; we = 0; adr = BASE;
        req = 1; idx = 2'd3;
        for (int k = 0; k < NC; k++) begin
            check("r_ack", 32'(ack), 32'(e_ack[k]));
            check("r_dat", dat, e_dat[k]);
            check("r_gnt", 32'(gnt), 32'(e_gnt[k]));
            check("r_vld", 32'(vld), 32'(e_vld[k]));
            check("r_byte", 32'(byt), 32'(e_byt[k]));
            if (e_gnt[k]) e_byt[k+1] = pick(id, idx);
            wbp = cyc && stb && (adr == BASE);
            if (k >= free_at && (wbp || req)) begin
                wwin = wbp && (!req || last_spi);
                if (wwin) begin
                    e_ack[k+2] = 1;
                    e_dat[k+2] = we ? 32'h0 : id;
                end else begin
                    e_gnt[k+1] = 1;
                    e_vld[k+2] = 1;
                end
                last_spi = !wwin;
                free_at = k + 3;
            end
            step();
            mask = $urandom;
            if (e_ack[k]) begin
                cyc = 0; stb = 0;
            end else if (bad_cnt > 0) begin
                bad_cnt--;
                if (bad_cnt == 0) begin
                    cyc = 0; stb = 0;
                end
            end else if (!stb && $urandom_range(0, 3) == 0) begin
                cyc = 1; stb = 1; we = 1'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    adr = BASE + 32'd4;
                    bad_cnt = $urandom_range(1, 5);
                end else begin
                    adr = BASE;
                end
            end
            if (e_vld[k]) begin
                if ($urandom_range(0, 1) == 1) req = 0;
                else idx = 2'($urandom);
            end else if (!req && $urandom_range(0, 2) == 0) begin
                req = 1; idx = 2'($urandom);
            end
        end
        cyc = 0; stb = 0; req = 0;
        repeat (4) step();

        // directed SPI byte lanes
        for (int i = 0; i < 4; i++) begin
            req = 1; idx = 2'(i);
            step();
            check("spi_gnt", 32'(gnt), 1);
            step();
            check("spi_vld", 32'(vld), 1);
            check("spi_byte", 32'(byt), 32'(exp_b[i]));
            req = 0;
            step();
            check("spi_vld_1cyc", 32'(vld), 0);
        end

        // recapture: mismatch then match, SPI held through capture
        rst = 1'b1;
        step();
        check("rst2_idv", 32'(idv), 0);
        mask = 32'h1; req = 1; idx = 2'd0;
        step();
        rst = 1'b0;
        repeat (S + 3) step();
        mask = 32'h2;
        repeat (2 * S - 4) step();
        check("mm_idv_early", 32'(idv), 0);
        check("mm_cnt", 32'(mmc), 1);
        step();
        check("mm_idv_rise", 32'(idv), 1);
        check("mm_cnt_hold", 32'(mmc), 1);
        check("held_no_vld", 32'(vld), 0);
        step();
        check("held_gnt", 32'(gnt), 1);
        step();
        check("held_vld", 32'(vld), 1);
        check("held_byte", 32'(byt), 32'h02);
        req = 0;
        step();
        cyc = 1; stb = 1; we = 0; adr = BASE;
        step();
        check("mm_wb_noack", 32'(ack), 0);
        step();
        check("mm_wb_ack", 32'(ack), 1);
        check("mm_wb_dat", dat, 32'h2);
        cyc = 0; stb = 0;
        step();

        // reset during the SPI grant cycle
        req = 1; idx = 2'd1;
        step();
        check("pre_rst_gnt", 32'(gnt), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_idv", 32'(idv), 0);
        check("arst_gnt", 32'(gnt), 0);
        check("arst_mm", 32'(mmc), 0);
        seen = 0;
        repeat (5) begin
            step();
            if (vld) seen = 1;
        end
        check("arst_no_vld", 32'(seen), 0);
        req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
